// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32I ALU issue stage: fn3 encoding,
// opcodes, funct7 values, the issued-entry record and the stage states.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD_SUB     = 3'd0,
    SLL         = 3'd1,
    SLT         = 3'd2,
    SLTU        = 3'd3,
    XOR         = 3'd4,
    SHIFT_RIGHT = 3'd5,
    OR          = 3'd6,
    AND         = 3'd7
  } operations_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_ZERO = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    operations_e fn3;
    logic        fn7_bit5;
    logic [4:0]  rd;
    logic        illegal;
    logic [31:0] pc;
  } issue_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } issue_state_e;

  function automatic logic is_shift(operations_e fn3);
    return (fn3 == SLL) || (fn3 == SHIFT_RIGHT);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Fetch-side and execute-side handshake bundle of the ALU issue stage.
// master = the issue stage itself, slave = its surrounding pipeline.
interface alu_issue_if;
  import alu_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  operations_e out_fn3;
  logic        out_fn7_bit5;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [31:0] out_pc;

  modport master (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_fn3, out_fn7_bit5, out_rd,
           out_illegal, out_pc
  );

  modport slave (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_fn3, out_fn7_bit5, out_rd,
           out_illegal, out_pc
  );

endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I OP/OP-IMM/LUI/AUIPC decode into an issue entry.
// ALU_ISSUE_ILLEGAL_CHECK_EN enables opcode/funct7 validation.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0]  i_instr,
  input  logic [31:0]  i_pc,
  input  logic [31:0]  i_rs1_data,
  input  logic [31:0]  i_rs2_data,
  output issue_entry_t o_entry
);

`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic [6:0]  w_opcode;
  logic [6:0]  w_funct7;
  operations_e w_fn3;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic        w_shift;

  assign w_opcode = i_instr[6:0];
  assign w_funct7 = i_instr[31:25];
  assign w_fn3    = operations_e'(i_instr[14:12]);
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_u  = {i_instr[31:12], 12'b0};
  assign w_shift  = is_shift(w_fn3);

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a latch.
    o_entry    = '0;
    o_entry.pc = i_pc;
    o_entry.rd = i_instr[11:7];
    case (w_opcode)
      OPC_OP: begin
        // The ALU shifts by all of b, so shift amounts are trimmed here.
        o_entry.a        = i_rs1_data;
        o_entry.b        = w_shift ? {27'b0, i_rs2_data[4:0]} : i_rs2_data;
        o_entry.fn3      = w_fn3;
        o_entry.fn7_bit5 = i_instr[30];
        o_entry.illegal  = CHECK_EN &&
          !((w_funct7 == FUNCT7_ZERO) ||
            ((w_funct7 == FUNCT7_ALT) && ((w_fn3 == ADD_SUB) || (w_fn3 == SHIFT_RIGHT))));
      end
      OPC_LUI: begin
        o_entry.b = w_imm_u;
      end
      OPC_AUIPC: begin
        o_entry.a = i_pc;
        o_entry.b = w_imm_u;
      end
      default: begin
        if (CHECK_EN && (w_opcode != OPC_OP_IMM)) begin
          o_entry.illegal = 1'b1;
        end else begin
          o_entry.a        = i_rs1_data;
          o_entry.b        = w_shift ? {27'b0, i_instr[24:20]} : w_imm_i;
          o_entry.fn3      = w_fn3;
          o_entry.fn7_bit5 = (w_fn3 == SHIFT_RIGHT) && i_instr[30];
          o_entry.illegal  = CHECK_EN &&
            (((w_fn3 == SLL) && (w_funct7 != FUNCT7_ZERO)) ||
             ((w_fn3 == SHIFT_RIGHT) && (w_funct7 != FUNCT7_ZERO) && (w_funct7 != FUNCT7_ALT)));
        end
      end
    endcase
    if (o_entry.illegal) o_entry.rd = '0;
  end

endmodule

// File: rtl/alu_issue.sv
// Two-entry (main + skid) registered issue stage feeding the ALU.
// Build option: ALU_ISSUE_ILLEGAL_CHECK_EN (see alu_issue_decode).
module alu_issue
  import alu_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_PC_TAG = '0
) (
  input logic         clk,
  input logic         rst_n,
  input logic         flush,
  alu_issue_if.master bus
);

  localparam issue_entry_t IDLE_ENTRY = '{
    a: '0, b: '0, fn3: ADD_SUB, fn7_bit5: 1'b0, rd: '0, illegal: 1'b0, pc: RESET_PC_TAG
  };

  issue_state_e r_state, w_next_state;
  logic         r_in_ready;
  issue_entry_t r_main, r_skid, w_dec, w_out;
  logic         w_accept, w_fire;
  logic         w_load_main_dec, w_load_main_skid, w_load_skid;

  alu_issue_decode u_decode (
    .i_instr    (bus.in_instr),
    .i_pc       (bus.in_pc),
    .i_rs1_data (bus.in_rs1_data),
    .i_rs2_data (bus.in_rs2_data),
    .o_entry    (w_dec)
  );

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_fire   = bus.out_valid & bus.out_ready;

  always_comb begin
    w_next_state     = r_state;
    w_load_main_dec  = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: if (w_accept) begin
        w_next_state    = ST_ONE;
        w_load_main_dec = 1'b1;
      end
      ST_ONE: begin
        if (w_accept && w_fire) begin
          w_load_main_dec = 1'b1;
        end else if (w_accept) begin
          w_next_state = ST_FULL;
          w_load_skid  = 1'b1;
        end else if (w_fire) begin
          w_next_state = ST_EMPTY;
        end
      end
      ST_FULL: if (w_fire) begin
        w_next_state     = ST_ONE;
        w_load_main_skid = 1'b1;
      end
      default: w_next_state = ST_EMPTY;
    endcase
    if (flush) begin
      w_next_state     = ST_EMPTY;
      w_load_main_dec  = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  // NOTE: state uses <= so every register samples pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= IDLE_ENTRY;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != ST_FULL);
      if (w_load_main_dec)       r_main <= w_dec;
      else if (w_load_main_skid) r_main <= r_skid;
    end
  end

  // NOTE: skid payload needs no reset; it is only read after being written in ONE.
  always_ff @(posedge clk) begin
    if (w_load_skid) r_skid <= w_dec;
  end

  assign w_out = (r_state == ST_EMPTY) ? IDLE_ENTRY : r_main;

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = (r_state != ST_EMPTY);
  assign bus.out_a        = w_out.a;
  assign bus.out_b        = w_out.b;
  assign bus.out_fn3      = w_out.fn3;
  assign bus.out_fn7_bit5 = w_out.fn7_bit5;
  assign bus.out_rd       = w_out.rd;
  assign bus.out_illegal  = w_out.illegal;
  assign bus.out_pc       = w_out.pc;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: queue-based reference model checked every
// cycle, plus directed literal checks for decode, backpressure, flush and reset.
module tb_alu_issue;
  import alu_pkg::*;

`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam logic [31:0] TAG = 32'h0000_0ACE;

  logic clk;
  logic rst_n;
  logic flush;
  alu_issue_if bus ();

  alu_issue #(.XLEN(32), .RESET_PC_TAG(TAG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference decode straight from the instruction-set rules.
  function automatic issue_entry_t ref_decode(input logic [31:0] instr, input logic [31:0] pc,
                                              input logic [31:0] rs1, input logic [31:0] rs2);
    issue_entry_t e;
    logic [6:0] opc   = instr[6:0];
    logic [2:0] f3    = instr[14:12];
    logic [6:0] f7    = instr[31:25];
    logic [31:0] imm_i = 32'($signed(instr) >>> 20);
    logic [31:0] imm_u = instr & 32'hFFFF_F000;
    bit shift = (f3 == 3'd1) || (f3 == 3'd5);
    bit bad   = 1'b0;
    e = '0;
    e.pc = pc;
    e.rd = instr[11:7];
    if (opc == 7'h33) begin
      e.a = rs1;
      e.b = shift ? (rs2 % 32) : rs2;
      e.fn3 = operations_e'(f3);
      e.fn7_bit5 = instr[30];
      bad = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    end else if (opc == 7'h37) begin
      e.b = imm_u;
    end else if (opc == 7'h17) begin
      e.a = pc;
      e.b = imm_u;
    end else if (opc == 7'h13 || !CHECK_EN) begin
      e.a = rs1;
      e.b = shift ? 32'(instr[24:20]) : imm_i;
      e.fn3 = operations_e'(f3);
      e.fn7_bit5 = (f3 == 3'd5) ? instr[30] : 1'b0;
      bad = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
    end else begin
      bad = 1'b1;
    end
    if (CHECK_EN && bad) begin
      e.illegal = 1'b1;
      e.rd = '0;
    end
    return e;
  endfunction

  function automatic issue_entry_t dut_entry();
    issue_entry_t e;
    e.a = bus.out_a;
    e.b = bus.out_b;
    e.fn3 = bus.out_fn3;
    e.fn7_bit5 = bus.out_fn7_bit5;
    e.rd = bus.out_rd;
    e.illegal = bus.out_illegal;
    e.pc = bus.out_pc;
    return e;
  endfunction

  // Model: FIFO of at most two decoded entries.
  issue_entry_t model_q[$];
  bit m_acc, m_fire;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin
      m_acc  = bus.in_valid && (model_q.size() < 2);
      m_fire = (model_q.size() > 0) && bus.out_ready;
      if (flush) begin
        model_q.delete();
      end else begin
        if (m_fire) void'(model_q.pop_front());
        if (m_acc) model_q.push_back(ref_decode(bus.in_instr, bus.in_pc,
                                                bus.in_rs1_data, bus.in_rs2_data));
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", 128'(bus.in_ready), 128'(model_q.size() < 2));
    check("out_valid", 128'(bus.out_valid), 128'(model_q.size() != 0));
    if (model_q.size() != 0) check("out_entry", 128'(dut_entry()), 128'(model_q[0]));
    else                     check("empty_pc", 128'(bus.out_pc), 128'(TAG));
  end

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic rdy);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc = pc;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
    bus.out_ready = rdy;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 5))
      0: w[6:0] = OPC_OP;
      1, 5: w[6:0] = OPC_OP_IMM;
      2: w[6:0] = OPC_LUI;
      3: w[6:0] = OPC_AUIPC;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  logic [31:0] t_instr [6] = '{32'h402080B3, 32'h002090B3, 32'h4030D093,
                               32'hFFF00093, 32'h12345097, 32'h4020C0B3};
  logic [31:0] t_pc    [6] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h100, 32'h20};
  logic [31:0] t_rs1   [6] = '{32'd5, 32'd9, 32'h80, 32'h11, 32'h33, 32'd1};
  logic [31:0] t_rs2   [6] = '{32'd7, 32'h23, 32'h55, 32'h66, 32'h77, 32'd2};
  logic [31:0] e_a     [6] = '{32'd5, 32'd9, 32'h80, 32'h11, 32'h100, 32'd1};
  logic [31:0] e_b     [6] = '{32'd7, 32'd3, 32'd3, 32'hFFFF_FFFF, 32'h1234_5000, 32'd2};
  logic [2:0]  e_fn3   [6] = '{3'd0, 3'd1, 3'd5, 3'd0, 3'd0, 3'd4};
  logic        e_f7    [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [4:0]  e_rd    [6] = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, CHECK_EN ? 5'd0 : 5'd1};
  logic        e_ill   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CHECK_EN};

  initial begin
    rst_n = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    #1 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_a_b", 128'({bus.out_a, bus.out_b}), 128'(0));
    check("rst_fn_rd_ill", 128'({bus.out_fn3, bus.out_fn7_bit5, bus.out_rd, bus.out_illegal}), 128'(0));
    check("rst_pc", 128'(bus.out_pc), 128'(TAG));

    // Back-to-back directed decodes with out_ready high.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, t_instr[i], t_pc[i], t_rs1[i], t_rs2[i], 1'b1);
      @(negedge clk);
      check("dir_valid", 128'(bus.out_valid), 128'(1));
      check("dir_a", 128'(bus.out_a), 128'(e_a[i]));
      check("dir_b", 128'(bus.out_b), 128'(e_b[i]));
      check("dir_fn3", 128'(bus.out_fn3), 128'(e_fn3[i]));
      check("dir_fn7_bit5", 128'(bus.out_fn7_bit5), 128'(e_f7[i]));
      check("dir_rd", 128'(bus.out_rd), 128'(e_rd[i]));
      check("dir_illegal", 128'(bus.out_illegal), 128'(e_ill[i]));
    end
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    @(negedge clk);
    check("drain_valid", 128'(bus.out_valid), 128'(0));
    check("drain_pc", 128'(bus.out_pc), 128'(TAG));

    // Backpressure: fill both entries, then release.
    drive(1'b1, 32'hFFF00093, 32'h200, 32'd1, 32'd2, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'hFFF00093, 32'h204, 32'd3, 32'd4, 1'b0);
    @(negedge clk);
    check("bp_full_in_ready", 128'(bus.in_ready), 128'(0));
    check("bp_first_pc", 128'(bus.out_pc), 128'(32'h200));
    drive(1'b1, 32'hFFF00093, 32'h208, 32'd5, 32'd6, 1'b1);
    @(negedge clk);
    check("bp_second_pc", 128'(bus.out_pc), 128'(32'h204));
    check("bp_in_ready_back", 128'(bus.in_ready), 128'(1));
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    @(negedge clk);
    check("bp_drained", 128'(bus.out_valid), 128'(0));

    // Flush while FULL with a pending input.
    drive(1'b1, 32'h002090B3, 32'h300, 32'd1, 32'd2, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h002090B3, 32'h304, 32'd1, 32'd2, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    check("flush_valid", 128'(bus.out_valid), 128'(0));
    check("flush_in_ready", 128'(bus.in_ready), 128'(1));
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    @(negedge clk);
    check("flush_no_survivor", 128'(bus.out_valid), 128'(0));

    // Asynchronous reset while FULL, between clock edges.
    drive(1'b1, 32'h12345097, 32'h400, 32'd1, 32'd2, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h12345097, 32'h404, 32'd1, 32'd2, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 128'(bus.out_valid), 128'(0));
    check("async_rst_in_ready", 128'(bus.in_ready), 128'(1));
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, rand_instr(), $urandom & 32'hFFFF_FFFC,
            $urandom, $urandom, $urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 31) == 0);
      @(negedge clk);
    end
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 1'b1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
